iob_axistream_out_mc: RTL

- Multi-channel, packetising AXI-Stream transmitter; next generation of the single-channel axistream_out peripheral.
- NCH independent system-side write channels, each buffered in its own FIFO.
- Whole packets are serialised DATA_W→TDATA_W onto one AXI-Stream master, arbitrated per packet, with TDEST carrying the source channel.
- Sits between CPU/DMA write logic and a stream sink, in a single clock domain.

---
 rtl/iob_axistream_out_mc_pkg.sv | 23 ++
 rtl/iob_axistream_out_mc_fifo.sv | 59 +++++
 rtl/iob_axistream_out_mc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/iob_axistream_out_mc_pkg.sv
// Shared constants and helpers for the multi-channel AXI-Stream transmitter.
package iob_axistream_out_mc_pkg;

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Output beats per input word (R)
  function automatic int calc_r(input int data_w, input int tdata_w);
    return data_w / tdata_w;
  endfunction

  // Lane counter width, at least one bit even when R == 1
  function automatic int calc_lane_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  // FIFO occupancy width: one extra bit so a full FIFO is representable
  function automatic int calc_cnt_w(input int fifo_addr_w);
    return fifo_addr_w + 1;
  endfunction

endpackage

// File: rtl/iob_axistream_out_mc_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is always on data_o.
module iob_axistream_out_mc_fifo
  import iob_axistream_out_mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              do_push;
  logic              do_pop;

  // Level can only reach 2**ADDR_W, so its top bit alone marks full.
  assign full_o  = level_o[ADDR_W];
  assign empty_o = (level_o == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rptr];

  // Storage array has no reset; pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (cke_i && do_push) mem[wptr] <= data_i;
  end

  // Pointer and occupancy tracking; push+pop together leaves level unchanged.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wptr    <= '0;
      rptr    <= '0;
      level_o <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        wptr    <= '0;
        rptr    <= '0;
        level_o <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (do_pop) rptr <= rptr + 1'b1;
        if (do_push && !do_pop) level_o <= level_o + 1'b1;
        else if (!do_push && do_pop) level_o <= level_o - 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_axistream_out_mc.sv
// Multi-channel packetising AXI-Stream transmitter. Each channel buffers
// DATA_W words in its own FIFO; whole packets are serialised LSB lane first
// onto one stream, TDEST carrying the source channel.
// Build option: IOB_AXISTREAM_OUT_MC_STRICT_PRIO_EN selects fixed priority
// (lowest eligible channel wins); undefined gives round-robin arbitration.
module iob_axistream_out_mc
  import iob_axistream_out_mc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TDATA_W     = 8,
  parameter int NCH         = 2,
  parameter int FIFO_ADDR_W = 4,
  parameter int LEN_W       = 16,
  parameter int DEST_W      = 1
) (
  input  logic                           clk_i,
  input  logic                           cke_i,
  input  logic                           arst_n_i,
  input  logic                           sw_rst_i,
  input  logic                           en_i,
  input  logic [NCH-1:0]                 in_valid_i,
  input  logic [NCH*DATA_W-1:0]          in_data_i,
  output logic [NCH-1:0]                 in_ready_o,
  input  logic [NCH*LEN_W-1:0]           nwords_i,
  output logic [NCH*(FIFO_ADDR_W+1)-1:0] level_o,
  output logic                           axis_tvalid_o,
  input  logic                           axis_tready_i,
  output logic [TDATA_W-1:0]             axis_tdata_o,
  output logic [DEST_W-1:0]              axis_tdest_o,
  output logic                           axis_tlast_o,
  output logic                           busy_o,
  output logic                           pkt_done_o
);

  localparam int R      = calc_r(DATA_W, TDATA_W);
  localparam int LANE_W = calc_lane_w(R);
  localparam int CNT_W  = calc_cnt_w(FIFO_ADDR_W);
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

  logic [0:0]        state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_found;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat;
  logic [LANE_W-1:0] lane;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    pop;
  logic [NCH-1:0]    eligible;
  logic [DATA_W-1:0] head [NCH];
  logic [DATA_W-1:0] head_sel;
  logic              hs;
  logic              last_beat;
  logic              lane_end;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    iob_axistream_out_mc_fifo #(
      .DATA_W(DATA_W),
      .ADDR_W(FIFO_ADDR_W)
    ) u_fifo (
      .clk_i   (clk_i),
      .cke_i   (cke_i),
      .arst_n_i(arst_n_i),
      .rst_i   (sw_rst_i),
      .push_i  (in_valid_i[c]),
      .data_i  (in_data_i[c*DATA_W +: DATA_W]),
      .pop_i   (pop[c]),
      .data_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .level_o (level_o[c*CNT_W +: CNT_W])
    );
    assign in_ready_o[c] = ~full[c];
    assign eligible[c]   = ~empty[c] & (nwords_i[c*LEN_W +: LEN_W] != '0);
    // The head word leaves on its last lane, or early when the packet ends.
    assign pop[c]        = hs & (ch == CH_W'(c)) & (lane_end | last_beat);
  end

  assign head_sel      = head[ch];
  assign busy_o        = (state == ST_SEND);
  assign axis_tvalid_o = busy_o & ~empty[ch];
  assign axis_tdata_o  = head_sel[int'(lane)*TDATA_W +: TDATA_W];
  assign axis_tdest_o  = busy_o ? DEST_W'(ch) : '0;
  assign last_beat     = (beat == len - 1'b1);
  assign lane_end      = (lane == LANE_W'(R-1));
  assign axis_tlast_o  = axis_tvalid_o & last_beat;
  assign hs            = axis_tvalid_o & axis_tready_i;
  assign pkt_done_o    = hs & last_beat;

`ifndef IOB_AXISTREAM_OUT_MC_STRICT_PRIO_EN
  logic [CH_W-1:0] rr;

  // Remember which channel finished last so the scan starts after it.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rr <= '0;
    end else if (cke_i) begin
      if (sw_rst_i) rr <= '0;
      else if (hs && last_beat) rr <= ch;
    end
  end

  // Round-robin: first eligible channel after the last one served.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = 1; i <= NCH; i++) begin
      int idx;
      idx = (int'(rr) + i) % NCH;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(idx);
      end
    end
  end
`else
  // Fixed priority: lowest-indexed eligible channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(i);
      end
    end
  end
`endif

  // Packet FSM: grant and latch length in IDLE, stream beats in SEND.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= ST_IDLE;
      ch    <= '0;
      len   <= '0;
      beat  <= '0;
      lane  <= '0;
    end else if (cke_i) begin
      if (sw_rst_i) begin
        state <= ST_IDLE;
        ch    <= '0;
        len   <= '0;
        beat  <= '0;
        lane  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (en_i && grant_found) begin
              state <= ST_SEND;
              ch    <= grant_ch;
              len   <= nwords_i[int'(grant_ch)*LEN_W +: LEN_W];
              beat  <= '0;
              lane  <= '0;
            end
          end
          ST_SEND: begin
            if (hs) begin
              beat <= beat + 1'b1;
              lane <= (R == 1) ? '0 : lane + 1'b1;
              if (last_beat) state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
